// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the shared-ALU arbiter.
//   - ALU control codes understood by the downstream combinational ALU
//   - arbiter FSM state encoding
//   - op_legal(): true for codes the ALU actually implements
package alu_pkg;

  localparam int ALU_CW = 4;

  localparam logic [ALU_CW-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_CW-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_CW-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_CW-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALU_CW-1:0] ALU_SLT = 4'b0111;
  localparam logic [ALU_CW-1:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  function automatic logic op_legal(input logic [ALU_CW-1:0] op);
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: op_legal = 1'b1;
      default:                                            op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: 2-way round-robin grant.
//   req[1:0]    request lines
//   last_grant  index of the requester granted most recently
//   grant[1:0]  one-hot (or zero) grant; on a tie the requester that was not
//               granted last wins
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one combinational ALU between two requesters.
//
// A request is accepted in IDLE (valid/ready), its op and operands are
// registered onto alu_ctrl/alu_data1/alu_data2, the ALU output is captured
// one cycle later (EXEC) into the owner's response registers, and the
// response is held in RESP until the owner takes it.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   reqN_valid/ready/op/a/b       request channel of requester N (0,1)
//   rspN_valid/ready/result/zero/err  response channel of requester N
//   alu_data1/alu_data2/alu_ctrl  registered ALU inputs
//   alu_result/alu_zero           ALU outputs
//   busy                          FSM not in IDLE
//
// Build option: define ALU_OP_CHECK_EN to short-circuit unimplemented op
// codes straight to a response with err=1 (ALU registers untouched).
// Without it every op runs through the ALU and rspN_err is tied low.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int DW = 32,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [CW-1:0] req0_op,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  output logic          rsp0_valid,
  input  logic          rsp0_ready,
  output logic [DW-1:0] rsp0_result,
  output logic          rsp0_zero,
  output logic          rsp0_err,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [CW-1:0] req1_op,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  output logic          rsp1_valid,
  input  logic          rsp1_ready,
  output logic [DW-1:0] rsp1_result,
  output logic          rsp1_zero,
  output logic          rsp1_err,
  output logic [DW-1:0] alu_data1,
  output logic [DW-1:0] alu_data2,
  output logic [CW-1:0] alu_ctrl,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_zero,
  output logic          busy
);

  state_t              state, state_nxt;
  logic                last_grant;
  logic                owner;
  logic [1:0]          grant;
  logic                accept;
  logic                sel;
  logic [CW-1:0]       sel_op;
  logic [DW-1:0]       sel_a, sel_b;
  logic                sel_bad;
  logic                rsp_take;

  logic [1:0]          rsp_valid_q;
  logic [1:0][DW-1:0]  rsp_result_q;
  logic [1:0]          rsp_zero_q;

  rr_arb2 u_arb (
    .req        ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Ready is masked during reset so nothing can be latched by a handshake
  // the reset branch would discard.
  assign req0_ready = (state == S_IDLE) && !rst && grant[0];
  assign req1_ready = (state == S_IDLE) && !rst && grant[1];
  assign accept     = req0_ready || req1_ready;

  assign sel    = grant[1];
  assign sel_op = sel ? req1_op : req0_op;
  assign sel_a  = sel ? req1_a  : req0_a;
  assign sel_b  = sel ? req1_b  : req0_b;

`ifdef ALU_OP_CHECK_EN
  assign sel_bad = !op_legal(sel_op);
`else
  assign sel_bad = 1'b0;
`endif

  assign rsp_take = (state == S_RESP) && (owner ? rsp1_ready : rsp0_ready);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = sel_bad ? S_RESP : S_EXEC;
      S_EXEC:  state_nxt = S_RESP;
      S_RESP:  if (rsp_take) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef ALU_OP_CHECK_EN
  logic [1:0] rsp_err_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      last_grant   <= 1'b1;  // requester 0 wins the first tie
      owner        <= 1'b0;
      alu_data1    <= '0;
      alu_data2    <= '0;
      alu_ctrl     <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= '0;
`ifdef ALU_OP_CHECK_EN
      rsp_err_q    <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner      <= sel;
        last_grant <= sel;
        if (!sel_bad) begin
          alu_ctrl  <= sel_op;
          alu_data1 <= sel_a;
          alu_data2 <= sel_b;
        end
`ifdef ALU_OP_CHECK_EN
        else begin
          // Illegal op: answer immediately, ALU inputs keep the last legal op.
          rsp_valid_q[sel]  <= 1'b1;
          rsp_result_q[sel] <= '0;
          rsp_zero_q[sel]   <= 1'b1;
          rsp_err_q[sel]    <= 1'b1;
        end
`endif
      end
      if (state == S_EXEC) begin
        rsp_valid_q[owner]  <= 1'b1;
        rsp_result_q[owner] <= alu_result;
        rsp_zero_q[owner]   <= alu_zero;
`ifdef ALU_OP_CHECK_EN
        rsp_err_q[owner]    <= 1'b0;
`endif
      end
      if (rsp_take) begin
        rsp_valid_q[owner] <= 1'b0;
`ifdef ALU_OP_CHECK_EN
        rsp_err_q[owner]   <= 1'b0;
`endif
      end
    end
  end

  assign rsp0_valid  = rsp_valid_q[0];
  assign rsp1_valid  = rsp_valid_q[1];
  assign rsp0_result = rsp_result_q[0];
  assign rsp1_result = rsp_result_q[1];
  assign rsp0_zero   = rsp_zero_q[0];
  assign rsp1_zero   = rsp_zero_q[1];
`ifdef ALU_OP_CHECK_EN
  assign rsp0_err    = rsp_err_q[0];
  assign rsp1_err    = rsp_err_q[1];
`else
  assign rsp0_err    = 1'b0;
  assign rsp1_err    = 1'b0;
`endif

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: self-checking bench for alu_share_arb with a behavioural
// ALU attached and a queue of expected responses.
module tb_alu_share_arb;
  import alu_pkg::*;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_zero, rsp0_err;
  logic [CW-1:0] req0_op;
  logic [DW-1:0] req0_a, req0_b, rsp0_result;
  logic          req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_zero, rsp1_err;
  logic [CW-1:0] req1_op;
  logic [DW-1:0] req1_a, req1_b, rsp1_result;
  logic [DW-1:0] alu_data1, alu_data2, alu_result;
  logic [CW-1:0] alu_ctrl;
  logic          alu_zero, busy;

  typedef struct packed {
    logic          owner;
    logic [DW-1:0] result;
    logic          zero;
    logic          err;
  } exp_t;

  exp_t          sb[$];
  exp_t          e;
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  logic [CW-1:0] last_op;
  logic [DW-1:0] last_a;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_share_arb #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err),
    .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
  );

  function automatic logic [DW-1:0] ref_alu(input logic [CW-1:0] op,
                                            input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    case (op)
      ALU_AND: ref_alu = a & b;
      ALU_OR:  ref_alu = a | b;
      ALU_ADD: ref_alu = a + b;
      ALU_SUB: ref_alu = a - b;
      ALU_SLT: ref_alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_NOR: ref_alu = ~(a | b);
      default: ref_alu = '0;
    endcase
  endfunction

  // The shared ALU the block drives.
  always_comb begin
    alu_result = ref_alu(alu_ctrl, alu_data1, alu_data2);
    alu_zero   = (alu_result == '0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) until the requester is ready; returns in that cycle,
  // before the edge that completes the handshake.
  task automatic wait_grant(input int idx, output bit got);
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if ((idx == 0 && req0_ready) || (idx == 1 && req1_ready)) begin
        got = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 0; req0_op = '0; req0_a = '0; req0_b = '0; rsp0_ready = 0;
    req1_valid = 0; req1_op = '0; req1_a = '0; req1_b = '0; rsp1_ready = 0;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=00", {rsp0_valid, rsp1_valid}); end
    checks++; if ({rsp0_err, rsp1_err, rsp0_zero, rsp1_zero} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {rsp0_err, rsp1_err, rsp0_zero, rsp1_zero}); end
    checks++; if (alu_ctrl !== '0 || alu_data1 !== '0 || alu_data2 !== '0) begin failures++; $display("FAIL reset_alu_regs got=%h/%h/%h exp=0", alu_ctrl, alu_data1, alu_data2); end
    checks++; if (rsp0_result !== '0 || rsp1_result !== '0) begin failures++; $display("FAIL reset_result got=%h/%h exp=0", rsp0_result, rsp1_result); end
    rst = 1'b0;
    tick();
    // Tie with last_grant=1 after reset: requester 0 must be offered.
    req0_valid = 1; req1_valid = 1;
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b01) begin failures++; $display("FAIL reset_tie_ready got=%b exp=01", {req1_ready, req0_ready}); end
    // Withdraw before the edge: nothing may be latched.
    req0_valid = 0; req1_valid = 0;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL drop_valid_busy got=%b exp=0", busy); end
  endtask

  task automatic test_fairness();
    int grants[$];
    int gcyc[$];
    int nrsp = 0;
    req0_op = ALU_SUB; req0_a = 9;     req0_b = 9;
    req1_op = ALU_OR;  req1_a = 'hF0;  req1_b = 'h0F;
    rsp0_ready = 1; rsp1_ready = 1;
    req0_valid = 1; req1_valid = 1;
    for (int k = 0; k < 40 && nrsp < 3; k++) begin
      #1;
      if (req0_ready) begin sb.push_back('{1'b0, ref_alu(ALU_SUB, 9, 9), 1'b1, 1'b0}); grants.push_back(0); gcyc.push_back(cyc); end
      if (req1_ready) begin sb.push_back('{1'b1, ref_alu(ALU_OR, 'hF0, 'h0F), 1'b0, 1'b0}); grants.push_back(1); gcyc.push_back(cyc); end
      tick();
      checks++; if (rsp0_valid && rsp1_valid) begin failures++; $display("FAIL fair_both_rsp got=11 exp=one"); end
      if (rsp0_valid || rsp1_valid) begin
        nrsp++;
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL fair_unexpected_rsp got=%b%b exp=none", rsp1_valid, rsp0_valid); end
        else begin
          e = sb.pop_front();
          if (e.owner == 1'b0 && (!rsp0_valid || rsp0_result !== e.result || rsp0_zero !== e.zero)) begin
            failures++; $display("FAIL fair_rsp0 got=%b/%h/%b exp=1/%h/%b", rsp0_valid, rsp0_result, rsp0_zero, e.result, e.zero);
          end else if (e.owner == 1'b1 && (!rsp1_valid || rsp1_result !== e.result || rsp1_zero !== e.zero)) begin
            failures++; $display("FAIL fair_rsp1 got=%b/%h/%b exp=1/%h/%b", rsp1_valid, rsp1_result, rsp1_zero, e.result, e.zero);
          end
        end
      end
    end
    req0_valid = 0; req1_valid = 0;
    checks++; if (nrsp != 3 || grants.size() < 3) begin failures++; $display("FAIL fair_timeout got=%0d rsps exp=3", nrsp); end
    else begin
      checks++; if (grants[0] != 0 || grants[1] != 1 || grants[2] != 0) begin failures++; $display("FAIL fair_order got=%0d%0d%0d exp=010", grants[0], grants[1], grants[2]); end
      checks++; if (gcyc[1] - gcyc[0] != 3 || gcyc[2] - gcyc[1] != 3) begin failures++; $display("FAIL fair_interval got=%0d,%0d exp=3,3", gcyc[1] - gcyc[0], gcyc[2] - gcyc[1]); end
    end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL fair_leftover got=%0d exp=0", sb.size()); sb.delete(); end
    tick();
  endtask

  task automatic test_single_op();
    bit got;
    req0_op = ALU_ADD; req0_a = 5; req0_b = 7; rsp0_ready = 1; req0_valid = 1;
    wait_grant(0, got);
    checks++; if (!got) begin failures++; $display("FAIL single_grant got=timeout exp=ready"); req0_valid = 0; return; end
    sb.push_back('{1'b0, ref_alu(ALU_ADD, 5, 7), 1'b0, 1'b0});
    tick();  // N+1
    req0_valid = 0;
    checks++; if (busy !== 1'b1 || rsp0_valid !== 1'b0) begin failures++; $display("FAIL single_n1 got=busy%b/vld%b exp=busy1/vld0", busy, rsp0_valid); end
    tick();  // N+2
    checks++; if (rsp0_valid !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL single_n2 got=vld%b/busy%b exp=vld1/busy1", rsp0_valid, busy); end
    e = sb.pop_front();
    checks++; if (rsp0_result !== e.result || rsp0_zero !== e.zero || rsp0_err !== e.err || rsp1_valid !== 1'b0) begin
      failures++; $display("FAIL single_rsp got=%h/%b/%b exp=%h/%b/%b", rsp0_result, rsp0_zero, rsp0_err, e.result, e.zero, e.err);
    end
    checks++; if (alu_ctrl !== ALU_ADD || alu_data1 !== 32'd5 || alu_data2 !== 32'd7) begin failures++; $display("FAIL single_alu_regs got=%h/%h/%h exp=2/5/7", alu_ctrl, alu_data1, alu_data2); end
    tick();  // N+3
    checks++; if (rsp0_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL single_done got=vld%b/busy%b exp=0/0", rsp0_valid, busy); end
  endtask

  task automatic test_backpressure();
    bit got;
    req1_op = ALU_SLT; req1_a = 3; req1_b = 4; rsp1_ready = 0; req1_valid = 1;
    wait_grant(1, got);
    checks++; if (!got) begin failures++; $display("FAIL bp_grant got=timeout exp=ready"); req1_valid = 0; return; end
    sb.push_back('{1'b1, ref_alu(ALU_SLT, 3, 4), 1'b0, 1'b0});
    tick();  // N+1
    req1_valid = 0;
    req0_op = ALU_AND; req0_a = 1; req0_b = 1; req0_valid = 1;
    tick();  // N+2
    e = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (rsp1_valid !== 1'b1 || rsp1_result !== e.result || rsp1_zero !== e.zero || req0_ready !== 1'b0 || rsp0_valid !== 1'b0) begin
        failures++; $display("FAIL bp_hold cyc%0d got=vld%b/%h/rdy0%b/rsp0%b exp=1/%h/0/0", i, rsp1_valid, rsp1_result, req0_ready, rsp0_valid, e.result);
      end
      tick();
    end
    req0_valid = 0;
    rsp1_ready = 1;
    tick();
    checks++; if (rsp1_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL bp_release got=vld%b/busy%b exp=0/0", rsp1_valid, busy); end
  endtask

  task automatic test_reset_mid();
    bit got;
    req0_op = ALU_NOR; req0_a = 0; req0_b = 0; rsp0_ready = 1; req0_valid = 1;
    wait_grant(0, got);
    checks++; if (!got) begin failures++; $display("FAIL mid_grant got=timeout exp=ready"); req0_valid = 0; return; end
    tick();  // EXEC
    req0_valid = 0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_exec_busy got=%b exp=1", busy); end
    rst = 1;
    tick();
    rst = 0;
    checks++; if ({rsp0_valid, rsp1_valid, busy, rsp0_err} !== 4'b0) begin failures++; $display("FAIL mid_cleared got=%b exp=0000", {rsp0_valid, rsp1_valid, busy, rsp0_err}); end
    req1_op = ALU_AND; req1_a = 'hC; req1_b = 'hA; rsp1_ready = 1; req1_valid = 1;
    wait_grant(1, got);
    checks++; if (!got) begin failures++; $display("FAIL mid_regrant got=timeout exp=ready"); req1_valid = 0; return; end
    sb.push_back('{1'b1, 32'd8, 1'b0, 1'b0});
    last_op = ALU_AND; last_a = 'hC;
    tick();
    req1_valid = 0;
    tick();
    e = sb.pop_front();
    checks++; if (rsp1_valid !== 1'b1 || rsp1_result !== e.result || rsp1_zero !== e.zero || rsp0_valid !== 1'b0) begin
      failures++; $display("FAIL mid_rsp got=%b/%h/%b exp=1/%h/%b", rsp1_valid, rsp1_result, rsp1_zero, e.result, e.zero);
    end
    tick();
  endtask

  task automatic test_illegal_op();
    bit got;
    req0_op = 4'b1010; req0_a = 1; req0_b = 1; rsp0_ready = 1; req0_valid = 1;
    wait_grant(0, got);
    checks++; if (!got) begin failures++; $display("FAIL ill_grant got=timeout exp=ready"); req0_valid = 0; return; end
`ifdef ALU_OP_CHECK_EN
    sb.push_back('{1'b0, 32'd0, 1'b1, 1'b1});
    tick();  // N+1
    req0_valid = 0;
    e = sb.pop_front();
    checks++; if (rsp0_valid !== 1'b1 || rsp0_result !== e.result || rsp0_zero !== e.zero || rsp0_err !== e.err) begin
      failures++; $display("FAIL ill_rsp got=%b/%h/%b/%b exp=1/%h/%b/%b", rsp0_valid, rsp0_result, rsp0_zero, rsp0_err, e.result, e.zero, e.err);
    end
    checks++; if (alu_ctrl !== last_op || alu_data1 !== last_a) begin failures++; $display("FAIL ill_alu_regs got=%h/%h exp=%h/%h", alu_ctrl, alu_data1, last_op, last_a); end
`else
    sb.push_back('{1'b0, ref_alu(4'b1010, 1, 1), 1'b1, 1'b0});
    tick();  // N+1
    req0_valid = 0;
    checks++; if (rsp0_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL ill_n1 got=vld%b/busy%b exp=0/1", rsp0_valid, busy); end
    tick();  // N+2
    e = sb.pop_front();
    checks++; if (rsp0_valid !== 1'b1 || rsp0_result !== e.result || rsp0_zero !== e.zero || rsp0_err !== e.err) begin
      failures++; $display("FAIL ill_rsp got=%b/%h/%b/%b exp=1/%h/%b/%b", rsp0_valid, rsp0_result, rsp0_zero, rsp0_err, e.result, e.zero, e.err);
    end
    checks++; if (alu_ctrl !== 4'b1010) begin failures++; $display("FAIL ill_alu_ctrl got=%h exp=a", alu_ctrl); end
`endif
    tick();
    checks++; if (busy !== 1'b0 || rsp0_valid !== 1'b0) begin failures++; $display("FAIL ill_done got=busy%b/vld%b exp=0/0", busy, rsp0_valid); end
  endtask

  initial begin
    last_op = '0; last_a = '0;
    test_reset();
    test_fairness();
    test_single_op();
    test_backpressure();
    test_reset_mid();
    test_illegal_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
